// File: rtl/rx_sync_window.sv
// Sync-word search window: keeps a 64-bit sliding window of received bits and runs
// an IDLE/FILL/SEARCH/FOUND sequence gated by a programmable search window length.
module rx_sync_window (
   input  logic        clk_6M,
   input  logic        rstz,
   input  logic        p_1us,
   input  logic        rxbit,
   input  logic        search_start,
   input  logic        search_abort,
   input  logic [9:0]  regi_searchwin,
   input  logic        pscorr_trgp,
   output logic [63:0] sync_in,
   output logic        correWindow,
   output logic        sync_found,
   output logic        search_timeout_p
);

   typedef enum logic [1:0] {StIdle, StFill, StSearch, StFound} state_e;

   state_e     state_q, state_d;
   logic [6:0] fillcnt_q, fillcnt_d;
   logic [9:0] wincnt_q, wincnt_d;
   logic       expire;
   logic       correwin_d, found_d, timeout_d;

   // State, counters, shift register and registered outputs
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         state_q          <= StIdle;
         fillcnt_q        <= '0;
         wincnt_q         <= '0;
         sync_in          <= '0;
         correWindow      <= 1'b0;
         sync_found       <= 1'b0;
         search_timeout_p <= 1'b0;
      end else begin
         state_q          <= state_d;
         fillcnt_q        <= fillcnt_d;
         wincnt_q         <= wincnt_d;
         correWindow      <= correwin_d;
         sync_found       <= found_d;
         search_timeout_p <= timeout_d;
         if (p_1us) sync_in <= {rxbit, sync_in[63:1]};
      end
   end

   always_comb begin
      state_d   = state_q;
      fillcnt_d = fillcnt_q;
      wincnt_d  = wincnt_q;
      expire    = 1'b0;
      if (search_abort) begin
         state_d   = StIdle;
         fillcnt_d = '0;
         wincnt_d  = '0;
      end else if (search_start) begin
         // Start from any state (re)arms the fill; a coincident p_1us is not counted
         state_d   = StFill;
         fillcnt_d = '0;
         wincnt_d  = '0;
      end else if (p_1us) begin
         unique case (state_q)
            StFill: begin
               fillcnt_d = fillcnt_q + 7'd1;
               if (fillcnt_q == 7'd63) begin
                  state_d  = StSearch;
                  wincnt_d = '0;
               end
            end
            StSearch: begin
               if (pscorr_trgp) begin
                  state_d = StFound;
               end else if (wincnt_q == regi_searchwin) begin
                  state_d = StIdle;
                  expire  = 1'b1;
               end else if (wincnt_q != 10'd1023) begin
                  wincnt_d = wincnt_q + 10'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      correwin_d = (state_d == StSearch);
      found_d    = (state_d == StFound);
      timeout_d  = expire;
   end

endmodule

// File: tb/tb_rx_sync_window.sv
// Directed self-checking bench for rx_sync_window: shift, fill, timeout, hit,
// collisions, restart and asynchronous reset.
module tb_rx_sync_window;

   logic        clk_6M = 1'b0;
   logic        rstz;
   logic        p_1us;
   logic        rxbit;
   logic        search_start;
   logic        search_abort;
   logic [9:0]  regi_searchwin;
   logic        pscorr_trgp;
   logic [63:0] sync_in;
   logic        correWindow;
   logic        sync_found;
   logic        search_timeout_p;

   int tests_run = 0;
   int tests_failed = 0;

   rx_sync_window dut (
      .clk_6M           (clk_6M),
      .rstz             (rstz),
      .p_1us            (p_1us),
      .rxbit            (rxbit),
      .search_start     (search_start),
      .search_abort     (search_abort),
      .regi_searchwin   (regi_searchwin),
      .pscorr_trgp      (pscorr_trgp),
      .sync_in          (sync_in),
      .correWindow      (correWindow),
      .sync_found       (sync_found),
      .search_timeout_p (search_timeout_p)
   );

   always #83 clk_6M = ~clk_6M;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_6M);
         #1;
      end
   endtask

   // One p_1us strobe cycle carrying bit b, followed by no gap
   task automatic pulse(input logic b);
      p_1us = 1'b1;
      rxbit = b;
      step(1);
      p_1us = 1'b0;
   endtask

   task automatic start_pulse();
      search_start = 1'b1;
      step(1);
      search_start = 1'b0;
   endtask

   task automatic fill_to_search();
      start_pulse();
      for (int i = 0; i < 64; i++) begin
         pulse(1'($urandom_range(1)));
         step(1);
      end
   endtask

   task automatic test_reset();
      rstz = 1'b0;
      step(2);
      tests_run++;
      if ({correWindow, sync_found, search_timeout_p} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_outputs got=%b want=000", {correWindow, sync_found, search_timeout_p});
      end
      tests_run++;
      if (sync_in !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_sync_in got=%h want=0", sync_in);
      end
      rstz = 1'b1;
      step(2);
   endtask

   task automatic test_shift();
      logic [63:0] pat;
      pat = 64'hA5A5_0F0F_1234_5678;
      pscorr_trgp = 1'b1;  // must be ignored in IDLE
      for (int i = 0; i < 64; i++) begin
         pulse(pat[i]);
         step(1);
      end
      pscorr_trgp = 1'b0;
      tests_run++;
      if (sync_in !== pat) begin
         tests_failed++;
         $display("FAIL shift_pattern got=%h want=%h", sync_in, pat);
      end
      step(5);
      tests_run++;
      if (sync_in !== pat) begin
         tests_failed++;
         $display("FAIL shift_hold got=%h want=%h", sync_in, pat);
      end
      tests_run++;
      if ({correWindow, sync_found} !== 2'b00) begin
         tests_failed++;
         $display("FAIL idle_ignore_hit got=%b want=00", {correWindow, sync_found});
      end
      pulse(1'b1);
      tests_run++;
      if (sync_in !== {1'b1, pat[63:1]}) begin
         tests_failed++;
         $display("FAIL shift_one got=%h want=%h", sync_in, {1'b1, pat[63:1]});
      end
   endtask

   task automatic test_fill();
      regi_searchwin = 10'd500;
      // start coincident with p_1us: shifts, but does not count
      search_start = 1'b1;
      pulse(1'b0);
      search_start = 1'b0;
      step(1);
      for (int i = 0; i < 63; i++) begin
         pulse(1'b0);
         step(1);
      end
      tests_run++;
      if (correWindow !== 1'b0) begin
         tests_failed++;
         $display("FAIL fill_63 got=%b want=0", correWindow);
      end
      pulse(1'b0);
      tests_run++;
      if (correWindow !== 1'b1) begin
         tests_failed++;
         $display("FAIL fill_64 got=%b want=1", correWindow);
      end
   endtask

   task automatic test_timeout();
      int pulses_seen;
      regi_searchwin = 10'd10;
      fill_to_search();
      pulses_seen = 0;
      for (int i = 0; i < 10; i++) begin
         pulse(1'b0);
         pulses_seen += int'(search_timeout_p);
         step(1);
      end
      tests_run++;
      if (pulses_seen !== 0 || correWindow !== 1'b1) begin
         tests_failed++;
         $display("FAIL timeout_early got=%0d/%b want=0/1", pulses_seen, correWindow);
      end
      pulse(1'b0);
      tests_run++;
      if ({search_timeout_p, correWindow} !== 2'b10) begin
         tests_failed++;
         $display("FAIL timeout_11th got=%b want=10", {search_timeout_p, correWindow});
      end
      step(1);
      tests_run++;
      if (search_timeout_p !== 1'b0) begin
         tests_failed++;
         $display("FAIL timeout_one_cycle got=%b want=0", search_timeout_p);
      end
      // regi_searchwin = 0 expires on the first strobe
      regi_searchwin = 10'd0;
      fill_to_search();
      pulse(1'b0);
      tests_run++;
      if ({search_timeout_p, correWindow} !== 2'b10) begin
         tests_failed++;
         $display("FAIL timeout_zero got=%b want=10", {search_timeout_p, correWindow});
      end
      step(1);
   endtask

   task automatic test_hit();
      regi_searchwin = 10'd100;
      fill_to_search();
      for (int i = 0; i < 5; i++) begin
         pulse(1'b1);
         step(1);
      end
      pscorr_trgp = 1'b1;
      step(1);
      pulse(1'b1);
      tests_run++;
      if ({sync_found, correWindow, search_timeout_p} !== 3'b100) begin
         tests_failed++;
         $display("FAIL hit_found got=%b want=100", {sync_found, correWindow, search_timeout_p});
      end
      pscorr_trgp = 1'b0;
      for (int i = 0; i < 120; i++) begin
         pulse(1'b0);
         step(1);
      end
      tests_run++;
      if ({sync_found, correWindow, search_timeout_p} !== 3'b100) begin
         tests_failed++;
         $display("FAIL hit_hold got=%b want=100", {sync_found, correWindow, search_timeout_p});
      end
      start_pulse();
      tests_run++;
      if ({sync_found, correWindow} !== 2'b00) begin
         tests_failed++;
         $display("FAIL found_rearm got=%b want=00", {sync_found, correWindow});
      end
      search_abort = 1'b1;
      step(1);
      search_abort = 1'b0;
   endtask

   task automatic test_collision();
      regi_searchwin = 10'd3;
      fill_to_search();
      for (int i = 0; i < 3; i++) begin
         pulse(1'b0);
         step(1);
      end
      pscorr_trgp = 1'b1;
      pulse(1'b0);
      pscorr_trgp = 1'b0;
      tests_run++;
      if ({sync_found, search_timeout_p, correWindow} !== 3'b100) begin
         tests_failed++;
         $display("FAIL collide_hit_expiry got=%b want=100",
                  {sync_found, search_timeout_p, correWindow});
      end
      step(1);
      tests_run++;
      if (search_timeout_p !== 1'b0) begin
         tests_failed++;
         $display("FAIL collide_no_pulse got=%b want=0", search_timeout_p);
      end
      // abort beats a hit that is also at expiry
      fill_to_search();
      for (int i = 0; i < 3; i++) begin
         pulse(1'b0);
         step(1);
      end
      pscorr_trgp  = 1'b1;
      search_abort = 1'b1;
      pulse(1'b0);
      pscorr_trgp  = 1'b0;
      search_abort = 1'b0;
      tests_run++;
      if ({sync_found, search_timeout_p, correWindow} !== 3'b000) begin
         tests_failed++;
         $display("FAIL collide_abort got=%b want=000",
                  {sync_found, search_timeout_p, correWindow});
      end
      step(1);
   endtask

   task automatic test_restart();
      regi_searchwin = 10'd200;
      fill_to_search();
      for (int i = 0; i < 4; i++) begin
         pulse(1'b0);
         step(1);
      end
      start_pulse();
      tests_run++;
      if (correWindow !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart_cw got=%b want=0", correWindow);
      end
      for (int i = 0; i < 63; i++) begin
         pulse(1'b0);
         step(1);
      end
      tests_run++;
      if (correWindow !== 1'b0) begin
         tests_failed++;
         $display("FAIL restart_fill63 got=%b want=0", correWindow);
      end
      pulse(1'b0);
      tests_run++;
      if (correWindow !== 1'b1) begin
         tests_failed++;
         $display("FAIL restart_fill64 got=%b want=1", correWindow);
      end
   endtask

   task automatic test_reset_mid();
      int pulses_seen;
      regi_searchwin = 10'd5;
      fill_to_search();
      for (int i = 0; i < 4; i++) begin
         pulse(1'b1);
         step(1);
      end
      #40 rstz = 1'b0;
      #1;
      tests_run++;
      if ({correWindow, sync_found, search_timeout_p} !== 3'b000 || sync_in !== 64'h0) begin
         tests_failed++;
         $display("FAIL reset_mid got=%b/%h want=000/0",
                  {correWindow, sync_found, search_timeout_p}, sync_in);
      end
      step(2);
      rstz = 1'b1;
      step(1);
      pulses_seen = 0;
      pscorr_trgp = 1'b1;
      for (int i = 0; i < 80; i++) begin
         pulse(1'b0);
         pulses_seen += int'(search_timeout_p) + int'(correWindow) + int'(sync_found);
         step(1);
      end
      pscorr_trgp = 1'b0;
      tests_run++;
      if (pulses_seen !== 0) begin
         tests_failed++;
         $display("FAIL reset_idle_activity got=%0d want=0", pulses_seen);
      end
   endtask

   initial begin
      rstz           = 1'b1;
      p_1us          = 1'b0;
      rxbit          = 1'b0;
      search_start   = 1'b0;
      search_abort   = 1'b0;
      regi_searchwin = 10'd0;
      pscorr_trgp    = 1'b0;
      #5;
      test_reset();
      test_shift();
      test_fill();
      test_timeout();
      test_hit();
      test_collision();
      test_restart();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
